prog_counter: RTL and testbench

//   Parametrised successor to the fixed 6-bit up-counter. Adds configurable width, modulus,
//   up/down direction, synchronous clear and load, wrap or saturate mode, and a clock-enable

---
 rtl/prog_counter_pkg.sv | 13 +
 rtl/prog_counter_prescaler.sv | 32 +++
 rtl/prog_counter.sv | 93 +++++++++
 tb/tb_prog_counter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable event/timebase counter:
// saturation-mode encodings and the prescaler phase-width helper.
package prog_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Width of the prescaler phase register; at least one bit even when PRESCALE is 1.
  function automatic int phase_w(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/prog_counter_prescaler.sv
// Clock-enable prescaler: tick fires on the PRESCALE-th enabled cycle;
// restart re-aligns the phase to 0 synchronously.
module prog_counter_prescaler
  import prog_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int            PW   = phase_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = en & (phase == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (restart) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Parametrised up/down event counter with modulus, wrap/saturate bound handling,
// prescaled enable, terminal-count pulse and sticky overflow flag.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int MODULO   = 64,
  parameter int MODE     = MODE_WRAP,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if ((WIDTH < 2) || (MODULO < 2) || (MODULO > (1 << WIDTH)) || (PRESCALE < 1)) begin : g_bad_params
    $error("prog_counter: illegal WIDTH/MODULO/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam bit               SAT     = (MODE == MODE_SAT);

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    if (v >= MAX_VAL) return SAT ? MAX_VAL : '0;
    return v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    if (v == '0) return SAT ? '0 : MAX_VAL;
    return v - WIDTH'(1);
  endfunction

  logic             tick;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;

  prog_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(clr | load),
    .tick   (tick)
  );

  // clr > load > tick > hold; tc only flags a tick taken while sitting on a bound
  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    ovf_nxt   = ovf;
    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (load) begin
      count_nxt = clamp(load_val);
    end else if (tick) begin
      if (up_dn) begin
        tc_nxt    = (count >= MAX_VAL);
        count_nxt = step_up(count);
      end else begin
        tc_nxt    = (count == '0);
        count_nxt = step_down(count);
      end
      ovf_nxt = ovf | tc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: four parameterisations share one stimulus stream and are
// compared every cycle against an arithmetic model, plus hand-computed scenario checks.
module tb_prog_counter;
  import prog_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
  logic [5:0] load_val = '0;
  logic [5:0] c0;
  logic [3:0] c1, c2;
  logic [4:0] c3;
  logic [3:0] tcv, ovfv;

  int nvec = 0;
  int nmis = 0;

  // Per-instance parameters: width, modulus, saturate flag, prescale
  int p_w[4]   = '{6, 4, 4, 5};
  int p_mod[4] = '{64, 10, 16, 10};
  int p_sat[4] = '{0, 0, 1, 0};
  int p_ps[4]  = '{1, 1, 1, 3};

  int m_cnt[4] = '{0, 0, 0, 0};
  int m_tc[4]  = '{0, 0, 0, 0};
  int m_ovf[4] = '{0, 0, 0, 0};
  int m_en[4]  = '{0, 0, 0, 0};  // enabled cycles seen since last realignment

  always #5 clk = ~clk;

  prog_counter d0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(c0), .tc(tcv[0]), .ovf(ovfv[0])
  );
  prog_counter #(.WIDTH(4), .MODULO(10), .MODE(MODE_WRAP), .PRESCALE(1)) d1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .count(c1), .tc(tcv[1]), .ovf(ovfv[1])
  );
  prog_counter #(.WIDTH(4), .MODULO(16), .MODE(MODE_SAT), .PRESCALE(1)) d2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .count(c2), .tc(tcv[2]), .ovf(ovfv[2])
  );
  prog_counter #(.WIDTH(5), .MODULO(10), .MODE(MODE_WRAP), .PRESCALE(3)) d3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[4:0]), .count(c3), .tc(tcv[3]), .ovf(ovfv[3])
  );

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: counts live in 0..MODULO-1, movement is modular arithmetic.
  always @(posedge clk or negedge rst) begin : model
    int lv, maxv;
    bit tick;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_en[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        maxv = p_mod[i] - 1;
        m_tc[i] = 0;
        if (clr) begin
          m_cnt[i] = 0; m_ovf[i] = 0; m_en[i] = 0;
        end else if (load) begin
          lv = int'(load_val) % (1 << p_w[i]);
          m_cnt[i] = (lv > maxv) ? maxv : lv;
          m_en[i] = 0;
        end else if (en) begin
          m_en[i] = m_en[i] + 1;
          tick = (m_en[i] % p_ps[i]) == 0;
          if (tick) begin
            if (up_dn) begin
              m_tc[i] = (m_cnt[i] == maxv);
              if (m_tc[i] && p_sat[i]) m_cnt[i] = maxv;
              else m_cnt[i] = (m_cnt[i] + 1) % p_mod[i];
            end else begin
              m_tc[i] = (m_cnt[i] == 0);
              if (m_tc[i] && p_sat[i]) m_cnt[i] = 0;
              else m_cnt[i] = (m_cnt[i] + p_mod[i] - 1) % p_mod[i];
            end
            if (m_tc[i]) m_ovf[i] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int act[4];
    act[0] = int'(c0); act[1] = int'(c1); act[2] = int'(c2); act[3] = int'(c3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_cnt%0d", i), act[i], m_cnt[i]);
      chk($sformatf("model_tc%0d", i), int'(tcv[i]), m_tc[i]);
      chk($sformatf("model_ovf%0d", i), int'(ovfv[i]), m_ovf[i]);
    end
  end

  int seq[7] = '{0, 0, 1, 1, 1, 2, 2};

  initial begin
    // Reset held, then release and count up 5 edges
    repeat (2) @(negedge clk);
    chk("rst_cnt0", int'(c0), 0);
    chk("rst_tc0", int'(tcv[0]), 0);
    chk("rst_ovf0", int'(ovfv[0]), 0);
    rst = 1'b1; en = 1'b1; up_dn = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_cnt0", int'(c0), 5);
    chk("t1_tc0", int'(tcv[0]), 0);
    chk("t1_ovf0", int'(ovfv[0]), 0);
    chk("t1_cnt3", int'(c3), 1);

    // Modulo-10 wrap going up
    repeat (4) @(negedge clk);
    chk("t2_cnt1_at9", int'(c1), 9);
    chk("t2_tc1_at9", int'(tcv[1]), 0);
    @(negedge clk);
    chk("t2_cnt1_wrap", int'(c1), 0);
    chk("t2_tc1_wrap", int'(tcv[1]), 1);
    chk("t2_ovf1_wrap", int'(ovfv[1]), 1);
    chk("t2_cnt0_10", int'(c0), 10);
    @(negedge clk);
    chk("t2_cnt1_after", int'(c1), 1);
    chk("t2_tc1_pulse", int'(tcv[1]), 0);
    chk("t2_ovf1_sticky", int'(ovfv[1]), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; up_dn = 1'b0;
    chk("t2_ovf1_clr", int'(ovfv[1]), 0);
    @(negedge clk);
    chk("t2_cnt1_down", int'(c1), 9);
    chk("t2_tc1_down", int'(tcv[1]), 1);
    chk("t2_cnt2_satlow", int'(c2), 0);
    chk("t2_tc2_satlow", int'(tcv[2]), 1);

    // Saturating counter at the top and bottom bounds
    load = 1'b1; load_val = 6'd14; up_dn = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("t3_load14", int'(c2), 14);
    chk("t3_load_clamp1", int'(c1), 9);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t3_sat_cnt_%0d", k), int'(c2), 15);
      chk($sformatf("t3_sat_tc_%0d", k), int'(tcv[2]), (k > 0) ? 1 : 0);
    end
    load = 1'b1; load_val = 6'd1; up_dn = 1'b0;
    @(negedge clk);
    load = 1'b0;
    chk("t3_load1", int'(c2), 1);
    @(negedge clk);
    chk("t3_down0", int'(c2), 0);
    chk("t3_down0_tc", int'(tcv[2]), 0);
    @(negedge clk);
    chk("t3_hold0", int'(c2), 0);
    chk("t3_hold0_tc", int'(tcv[2]), 1);

    // Prescale 3 stepping, then frozen phase across a disabled stretch
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; up_dn = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("t4_ps_%0d", k), int'(c3), seq[k]);
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t4_frozen_%0d", k), int'(c3), 2);
    end
    en = 1'b1;
    @(negedge clk);
    chk("t4_resume_a", int'(c3), 2);
    @(negedge clk);
    chk("t4_resume_b", int'(c3), 3);

    // Priority clr > load > tick, and load clamping
    load = 1'b1; load_val = 6'd9;
    @(negedge clk);
    chk("t5_load9", int'(c1), 9);
    clr = 1'b1; load_val = 6'd7;
    @(negedge clk);
    chk("t5_prio_cnt", int'(c1), 0);
    chk("t5_prio_tc", int'(tcv[1]), 0);
    chk("t5_prio_ovf", int'(ovfv[1]), 0);
    clr = 1'b0;
    @(negedge clk);
    chk("t5_load7", int'(c1), 7);
    load_val = 6'd20;
    @(negedge clk);
    load = 1'b0;
    chk("t5_load20_clamp", int'(c3), 9);
    chk("t5_load20_trunc", int'(c1), 4);

    // Asynchronous reset between edges
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_cnt6", int'(c0), 6);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_cnt0", int'(c0), 0);
    chk("t6_async_cnt3", int'(c3), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_ps_wait", int'(c3), 0);
    @(negedge clk);
    chk("t6_ps_first", int'(c3), 1);
    chk("t6_cnt0", int'(c0), 3);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 29) == 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 6'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        #1 chk("rnd_async_cnt0", int'(c0), 0);
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
